uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
UART receive-side framer: deserialises the 11-bit frame produced by the transmit path into a byte plus error flags. Frame order on the line is start(0), data[0]..data[7] (LSB first), parity, stop(1). The block oversamples the serial line using an external oversample strobe and mid-bit samples each bit. It delivers each received byte to the RX FIFO with a one-cycle valid pulse.

Parameters:
OVERSAMPLE, 16, sample_tick pulses per bit period; must be even and at least 4.
PARITY_ODD, 0, 0 selects even parity and 1 selects odd; the expected parity bit is the XOR of data, inverted when PARITY_ODD=1.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
serial_in  input  1  asynchronous UART line; idle level is 1
sample_tick  input  1  one-cycle strobe at OVERSAMPLE x baud from the baud generator
fifo_full  input  1  RX FIFO full indication
rx_data  output  8  last received byte
rx_valid  output  1  one-cycle pulse; rx_data and the error flags are valid while it is high
parity_err  output  1  parity mismatch on the last delivered frame
frame_err  output  1  stop bit sampled as 0 on the last delivered frame
overrun_err  output  1  one-cycle pulse; a frame completed while fifo_full was high and was dropped
rx_busy  output  1  high in every state except IDLE

Behaviour:
- Reset:
  - Reset is synchronous, active-high, clock clk, and has priority over all other inputs.
  - The 2-flop synchroniser and the previous-sample register reset to 1.
  - State resets to IDLE; tick counter, bit counter and shift register reset to 0.
  - All outputs reset to 0.
  - Reset asserted mid-frame discards the partial frame; no rx_valid is produced for it.
- Line input: serial_in passes through the 2-flop synchroniser (rx_s). Only the synchronised value is used.
- Tick gating: counters and state advance only on cycles where sample_tick=1. On all other cycles, state is held.
- States are IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a sample_tick where the previous rx_s sample is 1 and the current rx_s is 0, go to START with tick_cnt=0. A line held low, such as a break, never retriggers; a 1 must be seen first.
  - START: increment tick_cnt on each tick. When tick_cnt reaches OVERSAMPLE/2-1, sample rx_s.
    - rx_s=1: false start; return to IDLE.
    - rx_s=0: clear tick_cnt and bit_cnt, then go to DATA.
  - DATA: on each tick where tick_cnt reaches OVERSAMPLE-1, sample rx_s.
    - Shift right into shreg[7] so that LSB-first arrival yields shreg=data.
    - Clear tick_cnt and increment bit_cnt.
    - After the sample with bit_cnt=7, go to PARITY.
  - PARITY: sample the parity bit at OVERSAMPLE-1 ticks and store the mismatch in p_bad. Then go to STOP.
  - STOP: sample the stop bit at OVERSAMPLE-1 ticks and go to IDLE. On the next clk cycle:
    - If fifo_full=0: rx_valid=1 for one cycle. rx_data is loaded from shreg, parity_err from p_bad, and frame_err is set to the inverse of the stop sample.
    - If fifo_full=1: rx_valid stays 0 and overrun_err=1 for one cycle. rx_data and the error flags are not updated.
- Output holding: rx_data, parity_err and frame_err hold their values until the next delivered frame.
- Error frames: frames with a parity or framing error are still delivered, with the flags set.
- Latency: rx_valid is asserted exactly one clk cycle after the sample_tick that sampled the stop bit. A frame spans OVERSAMPLE/2 + 10*OVERSAMPLE ticks from the detected falling edge.
- Back-to-back frames: IDLE is entered mid-stop-bit, so a start edge arriving at the end of the stop bit is caught.
- Simultaneous events: if rx_valid output timing coincides with a new falling edge in IDLE, both occur; the new frame proceeds normally.

Test Plan:
- Valid frame: OVERSAMPLE=16, sample_tick every cycle, frame 0xA5 with parity 0 (even) and stop 1 -> one rx_valid pulse 1 cycle after the stop sample, rx_data=0xA5, parity_err=0, frame_err=0.
- Parity error: frame 0x3C with parity bit 1 under even parity -> rx_valid=1, rx_data=0x3C, parity_err=1, frame_err=0. Repeating with PARITY_ODD=1 -> parity_err=0.
- Framing error and break: frame 0x55 with stop bit 0, then line held low for 40 bit times -> exactly one rx_valid with frame_err=1 and no further frames. The line then goes to 1 and frame 0x12 is sent -> rx_data=0x12 and both error flags are 0.
- False start: 5-tick low glitch on serial_in from idle -> no rx_valid, rx_busy returns to 0 after the mid-start sample, next frame 0x81 is received correctly.
- Overrun and back-to-back frames: frames 0x01 and 0x02 sent with zero idle between them, with fifo_full=1 during the second stop bit -> rx_valid for 0x01, overrun_err pulse for the second frame, rx_data remains 0x01.
- Reset mid-frame: reset pulsed during data bit 4 of frame 0xF0 -> all outputs 0 and no rx_valid. Frame 0x0F sent afterwards -> rx_data=0x0F.

Source files
------------

// File: rtl/uart_rx_frame.sv
// ---------------------------------------------------------------------------
// uart_rx_frame
//   UART receive-side framer. Deserialises an 11-bit frame
//   (start=0, data[0..7] LSB first, parity, stop=1) into a byte plus error
//   flags. The line is oversampled with an external strobe and each bit is
//   sampled near its middle. Each received byte is handed to the RX FIFO
//   with a one-cycle valid pulse.
//
// Parameters
//   OVERSAMPLE  sample_tick pulses per bit period (even, >= 4)
//   PARITY_ODD  0: even parity, 1: odd parity
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   serial_in    asynchronous UART line, idles high
//   sample_tick  one-cycle strobe at OVERSAMPLE x baud
//   fifo_full    RX FIFO full indication
//   rx_data      last delivered byte
//   rx_valid     one-cycle pulse, rx_data and error flags valid
//   parity_err   parity mismatch on the last delivered frame
//   frame_err    stop bit sampled low on the last delivered frame
//   overrun_err  one-cycle pulse, a frame completed while the FIFO was full
//   rx_busy      high whenever the framer is not idle
// ---------------------------------------------------------------------------
module uart_rx_frame #(
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    input  logic       sample_tick,
    input  logic       fifo_full,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       rx_busy
);

    localparam int              TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]   HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]   BIT_LAST  = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state;
    logic            sync1;
    logic            rx_s;
    logic            rx_prev;
    logic [TW-1:0]   tick_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            p_bad;

    // Two-flop synchroniser; runs every clock so the line is never stale
    // when a tick arrives.
    // NOTE: every register is written with <= so all flops update from the
    // values they held before the edge, exactly as the hardware does.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= serial_in;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rx_prev     <= 1'b1;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            p_bad       <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            // Pulses default low; only the stop-sample tick raises them.
            rx_valid    <= 1'b0;
            overrun_err <= 1'b0;

            if (sample_tick) begin
                rx_prev <= rx_s;

                case (state)
                    IDLE: begin
                        // A falling edge needs a 1 seen on the previous tick,
                        // so a held-low (break) line never retriggers.
                        if (rx_prev && !rx_s) begin
                            state    <= START;
                            tick_cnt <= '0;
                        end
                    end

                    START: begin
                        if (tick_cnt == HALF_LAST) begin
                            tick_cnt <= '0;
                            if (rx_s) begin
                                state <= IDLE;          // glitch, not a start bit
                            end else begin
                                bit_cnt <= '0;
                                state   <= DATA;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end

                    DATA: begin
                        if (tick_cnt == BIT_LAST) begin
                            // LSB arrives first, so shifting in at the top
                            // leaves the byte in natural order after 8 bits.
                            shreg    <= {rx_s, shreg[7:1]};
                            tick_cnt <= '0;
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= PARITY;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end

                    PARITY: begin
                        if (tick_cnt == BIT_LAST) begin
                            p_bad    <= (^shreg ^ PARITY_ODD) ^ rx_s;
                            tick_cnt <= '0;
                            state    <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end

                    STOP: begin
                        if (tick_cnt == BIT_LAST) begin
                            // Back to IDLE mid-stop-bit so a start edge right
                            // at the end of the stop bit is still caught.
                            tick_cnt <= '0;
                            state    <= IDLE;
                            if (fifo_full) begin
                                overrun_err <= 1'b1;
                            end else begin
                                rx_valid   <= 1'b1;
                                rx_data    <= shreg;
                                parity_err <= p_bad;
                                frame_err  <= ~rx_s;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame
//   Self-checking bench for uart_rx_frame. Two instances share the line:
//   one with even parity, one with odd parity. Frames are described at the
//   bit level; the reference model derives the expected byte and flags from
//   the frame content and FIFO state, and a monitor collects what each DUT
//   actually delivered.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame;

    localparam int OS = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } rx_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       serial_in;
    logic       sample_tick;
    logic       fifo_full;

    logic [7:0] rx_data_e, rx_data_o;
    logic       rx_valid_e, rx_valid_o;
    logic       parity_err_e, parity_err_o;
    logic       frame_err_e, frame_err_o;
    logic       overrun_err_e, overrun_err_o;
    logic       rx_busy_e, rx_busy_o;

    uart_rx_frame #(.OVERSAMPLE(OS), .PARITY_ODD(1'b0)) dut_even (
        .clk         (clk),
        .reset       (reset),
        .serial_in   (serial_in),
        .sample_tick (sample_tick),
        .fifo_full   (fifo_full),
        .rx_data     (rx_data_e),
        .rx_valid    (rx_valid_e),
        .parity_err  (parity_err_e),
        .frame_err   (frame_err_e),
        .overrun_err (overrun_err_e),
        .rx_busy     (rx_busy_e)
    );

    uart_rx_frame #(.OVERSAMPLE(OS), .PARITY_ODD(1'b1)) dut_odd (
        .clk         (clk),
        .reset       (reset),
        .serial_in   (serial_in),
        .sample_tick (sample_tick),
        .fifo_full   (fifo_full),
        .rx_data     (rx_data_o),
        .rx_valid    (rx_valid_o),
        .parity_err  (parity_err_o),
        .frame_err   (frame_err_o),
        .overrun_err (overrun_err_o),
        .rx_busy     (rx_busy_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor ----------------
    rx_t  obs_e[$], obs_o[$];
    int   obs_ovr_e = 0, obs_ovr_o = 0;
    int   cyc = 0;
    int   last_valid_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid_e) begin
                obs_e.push_back('{rx_data_e, parity_err_e, frame_err_e});
                last_valid_cyc = cyc;
            end
            if (rx_valid_o)    obs_o.push_back('{rx_data_o, parity_err_o, frame_err_o});
            if (overrun_err_e) obs_ovr_e++;
            if (overrun_err_o) obs_ovr_o++;
        end
    end

    // ---------------- reference model ----------------
    rx_t        exp_e[$], exp_o[$];
    int         exp_ovr = 0;
    logic [7:0] last_data = 8'h00;

    // Expected outcome of one complete frame, from its bit content alone.
    task automatic model_frame(input logic [7:0] d, input logic pbit,
                               input logic sbit, input logic full);
        int ones;
        if (full) begin
            exp_ovr++;
        end else begin
            ones = $countones(d);
            exp_e.push_back('{d, pbit != ((ones % 2) == 1), !sbit});
            exp_o.push_back('{d, pbit != ((ones % 2) == 0), !sbit});
            last_data = d;
        end
    endtask

    // ---------------- drivers ----------------
    int gap = 0;   // idle clocks between sample ticks

    task automatic tick();
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic line_ticks(input logic lvl, input int n);
        serial_in = lvl;
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit,
                              input logic sbit, input logic full);
        line_ticks(1'b0, OS);
        for (int i = 0; i < 8; i++) line_ticks(d[i], OS);
        line_ticks(pbit, OS);
        fifo_full = full;
        line_ticks(sbit, OS);
        fifo_full = 1'b0;
        model_frame(d, pbit, sbit, full);
    endtask

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    // Compare everything delivered since the last call against the model.
    task automatic verify(input string tag);
        int n;
        check({tag, "/count_even"}, 32'(obs_e.size()), 32'(exp_e.size()));
        check({tag, "/count_odd"},  32'(obs_o.size()), 32'(exp_o.size()));
        check({tag, "/overrun_even"}, 32'(obs_ovr_e), 32'(exp_ovr));
        check({tag, "/overrun_odd"},  32'(obs_ovr_o), 32'(exp_ovr));
        n = (obs_e.size() < exp_e.size()) ? obs_e.size() : exp_e.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s/frame_even[%0d]", tag, i), 32'(obs_e[i]), 32'(exp_e[i]));
        n = (obs_o.size() < exp_o.size()) ? obs_o.size() : exp_o.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s/frame_odd[%0d]", tag, i), 32'(obs_o[i]), 32'(exp_o[i]));
        check({tag, "/hold_data_even"}, 32'(rx_data_e), 32'(last_data));
        check({tag, "/hold_data_odd"},  32'(rx_data_o), 32'(last_data));
        obs_e.delete(); obs_o.delete(); exp_e.delete(); exp_o.delete();
        obs_ovr_e = 0; obs_ovr_o = 0; exp_ovr = 0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        reset       = 1'b1;
        serial_in   = 1'b1;
        sample_tick = 1'b0;
        fifo_full   = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // Reset state
        check("reset/outputs_even",
              32'({rx_data_e, rx_valid_e, parity_err_e, frame_err_e, overrun_err_e, rx_busy_e}), 32'h0);
        check("reset/outputs_odd",
              32'({rx_data_o, rx_valid_o, parity_err_o, frame_err_o, overrun_err_o, rx_busy_o}), 32'h0);
        line_ticks(1'b1, 4);

        // Valid frame 0xA5, even parity bit; valid must land in the stop bit
        t0 = cyc;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        check("valid/latency_in_stop_bit",
              32'((last_valid_cyc >= t0 + 10*OS) && (last_valid_cyc <= t0 + 11*OS)), 32'd1);
        line_ticks(1'b1, 4);
        verify("valid_a5");

        // Parity error: 0x3C with parity bit 1 (bad for even, good for odd)
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        line_ticks(1'b1, 4);
        verify("parity_3c");

        // Framing error followed by a 40-bit break, then a clean frame
        send_frame(8'h55, even_par(8'h55), 1'b0, 1'b0);
        line_ticks(1'b0, 40*OS);
        verify("break_55");
        line_ticks(1'b1, 2*OS);
        send_frame(8'h12, even_par(8'h12), 1'b1, 1'b0);
        line_ticks(1'b1, 4);
        verify("after_break_12");

        // False start: 5-tick glitch
        line_ticks(1'b0, 5);
        check("false_start/busy_during", 32'(rx_busy_e), 32'd1);
        line_ticks(1'b1, 10);
        check("false_start/busy_after", 32'(rx_busy_e), 32'd0);
        send_frame(8'h81, even_par(8'h81), 1'b1, 1'b0);
        line_ticks(1'b1, 4);
        verify("false_start_81");

        // Back-to-back frames, second one overruns
        send_frame(8'h01, even_par(8'h01), 1'b1, 1'b0);
        send_frame(8'h02, even_par(8'h02), 1'b1, 1'b1);
        line_ticks(1'b1, 4);
        verify("overrun_b2b");

        // Reset during data bit 4 of 0xF0
        line_ticks(1'b0, OS);
        for (int i = 0; i < 4; i++) line_ticks(1'b0, OS);   // bits 0..3 of 0xF0
        line_ticks(1'b1, OS/2);                              // into bit 4
        do_reset();
        serial_in = 1'b1;
        check("midreset/outputs",
              32'({rx_data_e, rx_valid_e, parity_err_e, frame_err_e, overrun_err_e, rx_busy_e}), 32'h0);
        last_data = 8'h00;
        line_ticks(1'b1, 2*OS);
        verify("midreset_partial");
        send_frame(8'h0F, even_par(8'h0F), 1'b1, 1'b0);
        line_ticks(1'b1, 4);
        verify("midreset_0f");

        // Randomised frames with random tick spacing, errors and FIFO state
        for (int k = 0; k < 24; k++) begin
            logic [7:0] d;
            logic       pb, sb, fl;
            gap = $urandom_range(0, 2);
            d   = 8'($urandom_range(0, 255));
            pb  = 1'($urandom_range(0, 1));
            sb  = ($urandom_range(0, 5) != 0);
            fl  = ($urandom_range(0, 4) == 0);
            send_frame(d, pb, sb, fl);
            line_ticks(1'b1, sb ? $urandom_range(0, 3) : $urandom_range(2, 4));
        end
        gap = 0;
        line_ticks(1'b1, 8);
        verify("random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
